// File: rtl/wb_reg_file.sv
// Writeback-stage register file: one write port fed by MEM/WB and two combinational read ports
// with same-cycle write-to-read bypass. The register at ZERO_REG reads as zero and ignores writes.
module wb_reg_file #(
  parameter  int unsigned DATA_W   = 64,
  parameter  int unsigned NUM_REGS = 32,
  parameter  int unsigned ZERO_REG = 31,
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_fire;

  assign wr_fire = wr_en && (wr_addr != ZERO_ADDR);

  // The ZERO_REG entry is never written, so it holds its reset value and folds away.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_fire) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Zero select outranks the bypass; reset forces both ports to zero.
  always_comb begin
    rd_data_a = regs[rd_addr_a];
    if (wr_en && (wr_addr == rd_addr_a)) rd_data_a = wr_data;
    if (!reset || (rd_addr_a == ZERO_ADDR)) rd_data_a = '0;
  end

  always_comb begin
    rd_data_b = regs[rd_addr_b];
    if (wr_en && (wr_addr == rd_addr_b)) rd_data_b = wr_data;
    if (!reset || (rd_addr_b == ZERO_ADDR)) rd_data_b = '0;
  end

endmodule

// File: tb/tb_wb_reg_file.sv
// Scoreboard bench for wb_reg_file: a driver applies stimulus and queues the expected read data
// from an array model; a monitor on the falling edge pops and compares against the read ports.
module tb_wb_reg_file;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [4:0]  rd_addr_a = '0;
  logic [4:0]  rd_addr_b = '0;
  logic [63:0] rd_data_a;
  logic [63:0] rd_data_b;

  int total = 0;
  int bad = 0;

  typedef struct {
    string       name;
    logic [63:0] exp_a;
    logic [63:0] exp_b;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] model [32];

  wb_reg_file #(.DATA_W(64), .NUM_REGS(32), .ZERO_REG(31)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_read(input logic [4:0] addr);
    if (!reset)                          return 64'd0;
    if (addr == 5'd31)                   return 64'd0;
    if (wr_en && (wr_addr == addr))      return wr_data;
    return model[addr];
  endfunction

  // One cycle: retire the write committed at this edge into the model, then drive new inputs.
  task automatic step(input logic r, input logic w, input logic [4:0] wa, input logic [63:0] wd,
                      input logic [4:0] ra, input logic [4:0] rb, input string nm);
    exp_t e;
    @(posedge clk);
    if (reset && wr_en && (wr_addr != 5'd31)) model[wr_addr] = wr_data;
    #1;
    reset = r; wr_en = w; wr_addr = wa; wr_data = wd; rd_addr_a = ra; rd_addr_b = rb;
    if (!r) begin
      for (int i = 0; i < 32; i++) model[i] = 64'd0;
    end
    e.name  = nm;
    e.exp_a = ref_read(ra);
    e.exp_b = ref_read(rb);
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (rd_data_a !== e.exp_a) begin
          bad++;
          $display("FAIL %s port A: got %h expected %h", e.name, rd_data_a, e.exp_a);
        end
        total++;
        if (rd_data_b !== e.exp_b) begin
          bad++;
          $display("FAIL %s port B: got %h expected %h", e.name, rd_data_b, e.exp_b);
        end
      end
    end
  end

  initial begin : driver
    logic [4:0]  wa, ra, rb;
    logic [63:0] wd;
    logic        w, r;
    for (int i = 0; i < 32; i++) model[i] = 64'd0;

    step(1'b0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd31, "reset_init");
    step(1'b1, 1'b0, 5'd0, 64'd0, 5'd1, 5'd2, "after_release");

    // 1: fill some registers, then hold reset and sweep every address
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 5'(i), 64'hA5A5_0000_0000_0000 | 64'(i + 1), 5'(i), 5'(7 - i), "fill");
    end
    step(1'b1, 1'b0, 5'd0, 64'd0, 5'd3, 5'd7, "fill_readback");
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b1, 5'(i), 64'hFFFF_FFFF_FFFF_FFFF, 5'(i), 5'(31 - i), "reset_hold_sweep");
    end
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b0, 5'd0, 64'd0, 5'(i), 5'(31 - i), "post_reset_sweep");
    end

    // 2: write then read next cycle
    step(1'b1, 1'b1, 5'd5, 64'hDEAD_BEEF_0123_4567, 5'd0, 5'd0, "write_x5");
    step(1'b1, 1'b0, 5'd0, 64'd0, 5'd5, 5'd6, "read_x5");

    // 3: bypass on both ports
    step(1'b1, 1'b1, 5'd9, 64'h1, 5'd0, 5'd0, "write_x9");
    step(1'b1, 1'b1, 5'd9, 64'h2, 5'd9, 5'd9, "bypass_x9");
    step(1'b1, 1'b0, 5'd9, 64'h0, 5'd9, 5'd9, "stored_x9");

    // 4: XZR write dropped, zero wins over bypass
    step(1'b1, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31, "xzr_write");
    step(1'b1, 1'b0, 5'd31, 64'd0, 5'd31, 5'd30, "xzr_after");

    // 5: no write and no bypass with wr_en low
    step(1'b1, 1'b1, 5'd3, 64'h77, 5'd0, 5'd0, "write_x3");
    step(1'b1, 1'b0, 5'd3, 64'hFF, 5'd3, 5'd3, "wr_en_low");
    step(1'b1, 1'b0, 5'd0, 64'd0, 5'd3, 5'd9, "x3_held");

    // 6: back-to-back writes, reset dropped between edges
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b1, 5'(i), 64'h1111_0000_0000_0000 * 64'(i), 5'(i), 5'(i - 1), "b2b_write");
    end
    step(1'b0, 1'b1, 5'd5, 64'h5555, 5'd4, 5'd5, "async_drop");
    step(1'b0, 1'b1, 5'd6, 64'h6666, 5'd1, 5'd2, "async_hold");
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 5'd0, 64'd0, 5'(i), 5'(i + 8), "async_after");
    end

    // randomized traffic with occasional reset and deliberate address collisions
    for (int n = 0; n < 400; n++) begin
      r  = ($urandom_range(0, 39) != 0);
      w  = ($urandom_range(0, 3) != 0);
      wa = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      wd = {$urandom, $urandom};
      ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      step(r, w, wa, wd, ra, rb, "random");
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
